// File: rtl/alu_multicycle_exec_pkg.sv
// Shared op codes, FSM states and shift-mode decode for the multicycle execute ALU.
package alu_multicycle_exec_pkg;

  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_ADD              = 4'd1;
  localparam logic [3:0] ALU_SUB              = 4'd2;
  localparam logic [3:0] ALU_XOR              = 4'd3;
  localparam logic [3:0] ALU_OR               = 4'd4;
  localparam logic [3:0] ALU_AND              = 4'd5;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd6;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd7;
  localparam logic [3:0] ALU_SHIFTL           = 4'd8;
  localparam logic [3:0] ALU_SHIFTR           = 4'd9;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd10;

  typedef enum logic [1:0] {EXS_IDLE, EXS_SHIFT, EXS_DONE} exs_state_e;
  typedef enum logic [1:0] {SH_LEFT, SH_RIGHT, SH_ARITH} shift_mode_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SHIFTL) || (op == ALU_SHIFTR) || (op == ALU_SHIFTR_ARITH);
  endfunction

  function automatic shift_mode_e shift_mode(input logic [3:0] op);
    case (op)
      ALU_SHIFTL:       return SH_LEFT;
      ALU_SHIFTR_ARITH: return SH_ARITH;
      default:          return SH_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/alu_multicycle_exec_if.sv
// Operand/result handshake bundle between the decoder side and the execute ALU.
interface alu_multicycle_exec_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;

  modport master (output in_valid, SrcA, SrcB, ALUControl, out_ready,
                  input  in_ready, out_valid, Result, Zero);
  modport slave  (input  in_valid, SrcA, SrcB, ALUControl, out_ready,
                  output in_ready, out_valid, Result, Zero);
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: shift register, down-counter and fill-bit select.
module alu_serial_shifter
  import alu_multicycle_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_step,
  input  shift_mode_e      i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_q_nxt,
  output logic             o_last
);
  logic [WIDTH-1:0] r_q;
  logic [SHW-1:0]   r_cnt;
  shift_mode_e      r_mode;
  logic [WIDTH-1:0] w_q_nxt;

  // o_q_nxt is the register value after this step, so the parent can capture the final result on the same edge
  always_comb begin
    w_q_nxt = '0;
    case (r_mode)
      SH_LEFT:  w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
      SH_ARITH: w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      default:  w_q_nxt = {1'b0, r_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_mode <= SH_LEFT;
    end else if (i_clr) begin
      r_cnt  <= '0;
    end else if (i_load) begin
      r_q    <= i_data;
      r_cnt  <= i_shamt;
      r_mode <= i_mode;
    end else if (i_step && (r_cnt != '0)) begin
      r_q    <= w_q_nxt;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_q_nxt = w_q_nxt;
  assign o_last  = (r_cnt == SHW'(1));
endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare, serial shifts, registered Result/Zero with valid/ready.
module alu_multicycle_exec
  import alu_multicycle_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  alu_multicycle_exec_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  exs_state_e       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_shift;
  logic             w_shamt_zero;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_sh_last;

  assign w_in_ready   = !flush && ((r_state == EXS_IDLE) ||
                                   ((r_state == EXS_DONE) && bus.out_ready));
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_is_shift   = is_shift_op(bus.ALUControl);
  assign w_shamt_zero = (bus.SrcB[SHW-1:0] == '0);

  // Shifts with a zero amount complete through this path and return SrcA unchanged
  always_comb begin
    w_alu_res = '0;
    case (bus.ALUControl)
      ALU_ADD:              w_alu_res = bus.SrcA + bus.SrcB;
      ALU_SUB:              w_alu_res = bus.SrcA - bus.SrcB;
      ALU_XOR:              w_alu_res = bus.SrcA ^ bus.SrcB;
      ALU_OR:               w_alu_res = bus.SrcA | bus.SrcB;
      ALU_AND:              w_alu_res = bus.SrcA & bus.SrcB;
      ALU_LESS_THAN_SIGNED: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      ALU_LESS_THAN:        w_alu_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      ALU_SHIFTL, ALU_SHIFTR, ALU_SHIFTR_ARITH: w_alu_res = bus.SrcA;
      default:              w_alu_res = '0;
    endcase
  end

  alu_serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_load  (w_accept && w_is_shift),
    .i_step  (r_state == EXS_SHIFT),
    .i_mode  (shift_mode(bus.ALUControl)),
    .i_data  (bus.SrcA),
    .i_shamt (bus.SrcB[SHW-1:0]),
    .o_q_nxt (w_sh_nxt),
    .o_last  (w_sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EXS_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= EXS_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EXS_SHIFT: begin
          if (w_sh_last) begin
            r_result    <= w_sh_nxt;
            r_zero      <= (w_sh_nxt == '0);
            r_out_valid <= 1'b1;
            r_state     <= EXS_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            if (w_is_shift && !w_shamt_zero) begin
              r_out_valid <= 1'b0;
              r_state     <= EXS_SHIFT;
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= EXS_DONE;
            end
          end else if ((r_state == EXS_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= EXS_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Result    = r_result;
  assign bus.Zero      = r_zero;
endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Directed-vector bench for alu_multicycle_exec with hand-computed expectations.
module tb_alu_multicycle_exec;
  import alu_multicycle_exec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_total = 0;
  int   n_pass  = 0;
  int   lat;
  logic seen;

  alu_multicycle_exec_if #(.WIDTH(32)) bus ();

  alu_multicycle_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Presents one op for a single edge, then waits (bounded) for out_valid and reports latency
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int l);
    bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b; bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 64) begin
      step(1);
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.SrcA = '0; bus.SrcB = '0; bus.ALUControl = ALU_NONE;
    step(2);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.Result,         32'd0);
    chk("rst_zero",      32'(bus.Zero),      32'd0);
    rst = 1'b0;
    step(1);
    chk("idle_in_ready", 32'(bus.in_ready),  32'd1);

    run_op(ALU_SUB, 32'd5, 32'd5, lat);
    chk("sub_lat",  lat, 1);
    chk("sub_res",  bus.Result, 32'd0);
    chk("sub_zero", 32'(bus.Zero), 32'd1);

    run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, lat);
    chk("add_wrap_res",  bus.Result, 32'd0);
    chk("add_wrap_zero", 32'(bus.Zero), 32'd1);

    run_op(ALU_LESS_THAN_SIGNED, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_res",  bus.Result, 32'd1);
    chk("slt_zero", 32'(bus.Zero), 32'd0);

    run_op(ALU_LESS_THAN, 32'hFFFF_FFFF, 32'd1, lat);
    chk("sltu_res", bus.Result, 32'd0);

    run_op(ALU_OR, 32'h0000_00F0, 32'h0000_0F00, lat);
    chk("or_res", bus.Result, 32'h0000_0FF0);

    run_op(4'hF, 32'h1234_5678, 32'h1, lat);
    chk("unlisted_res",  bus.Result, 32'd0);
    chk("unlisted_zero", 32'(bus.Zero), 32'd1);

    run_op(ALU_SHIFTR_ARITH, 32'h8000_0000, 32'd31, lat);
    chk("sra31_lat", lat, 32);
    chk("sra31_res", bus.Result, 32'hFFFF_FFFF);

    run_op(ALU_SHIFTL, 32'd1, 32'h0000_0024, lat);
    chk("sll4_lat", lat, 5);
    chk("sll4_res", bus.Result, 32'd16);

    run_op(ALU_SHIFTR, 32'h8000_0000, 32'd4, lat);
    chk("srl4_lat", lat, 5);
    chk("srl4_res", bus.Result, 32'h0800_0000);

    run_op(ALU_SHIFTL, 32'h0000_1234, 32'h0000_0020, lat);
    chk("sh0_lat", lat, 1);
    chk("sh0_res", bus.Result, 32'h0000_1234);

    // asynchronous reset pulse in the middle of a cycle while a result is valid
    run_op(ALU_ADD, 32'd3, 32'd4, lat);
    chk("add_res", bus.Result, 32'd7);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result",    bus.Result,         32'd0);
    rst = 1'b0;
    step(1);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);

    bus.out_ready = 1'b0;
    run_op(ALU_AND, 32'h0000_FF00, 32'h0000_0FF0, lat);
    chk("and_res", bus.Result, 32'h0000_0F00);
    bus.SrcA = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("hold_valid",    32'(bus.out_valid), 32'd1);
      chk("hold_result",   bus.Result,         32'h0000_0F00);
      chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    bus.ALUControl = ALU_XOR; bus.SrcA = 32'h0000_F0F0; bus.SrcB = 32'h0000_FF00;
    bus.in_valid = 1'b1;
    #1;
    chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
    step(1);
    bus.in_valid = 1'b0;
    chk("handoff_valid", 32'(bus.out_valid), 32'd1);
    chk("handoff_res",   bus.Result,         32'h0000_0FF0);
    chk("handoff_zero",  32'(bus.Zero),      32'd0);
    step(1);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // flush three cycles into a ten-bit shift
    bus.ALUControl = ALU_SHIFTL; bus.SrcA = 32'd1; bus.SrcB = 32'd10; bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(2);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step(1);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen = 1'b1;
      step(1);
    end
    chk("flush_no_valid",  32'(seen),          32'd0);
    chk("flush_idle_rdy",  32'(bus.in_ready),  32'd1);

    flush = 1'b1;
    bus.ALUControl = ALU_ADD; bus.SrcA = 32'd1; bus.SrcB = 32'd1; bus.in_valid = 1'b1;
    step(1);
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_noacc_0", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("flush_noacc_1", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
